mux_scanner: RTL and testbench

Sequential scan controller placed directly upstream and downstream of `Mux_8x1`. It drives the mux select lines `sl_2..sl_0` through channels 0..7, waits a programmable settle time on each, and samples the mux output `y`. It packs the eight samples into one byte and hands that byte to a consumer over a valid/ready handshake. One scan runs per `start` request.

---
 rtl/mux_scanner_pkg.sv | 6 +
 rtl/mux_scanner_if.sv | 31 +++
 rtl/mux_scan_settle_timer.sv | 23 ++
 rtl/mux_scanner.sv | 92 +++++++++
 tb/tb_mux_scanner.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/mux_scanner_pkg.sv
// mux_scanner_pkg: shared state type and channel constants for the 8-channel mux scanner
package mux_scanner_pkg;
    localparam int NUM_CH = 8;
    localparam int SEL_W  = 3;
    typedef enum logic [1:0] {IDLE, SETTLE, DONE} scan_state_t;
endpackage

// File: rtl/mux_scanner_if.sv
// mux_scanner_if: mux select/sample lines plus the result valid/ready handshake.
// The changed flag exists only when MUX_SCANNER_CHANGE_EN is defined.
interface mux_scanner_if;
    import mux_scanner_pkg::*;
    logic              start;
    logic              y;
    logic              ready;
    logic              sl_2;
    logic              sl_1;
    logic              sl_0;
    logic              busy;
    logic [NUM_CH-1:0] data;
    logic              valid;
`ifdef MUX_SCANNER_CHANGE_EN
    logic              changed;
`endif
    modport master (
        input  start, y, ready,
        output sl_2, sl_1, sl_0, busy, data, valid
`ifdef MUX_SCANNER_CHANGE_EN
        , output changed
`endif
    );
    modport slave (
        output start, y, ready,
        input  sl_2, sl_1, sl_0, busy, data, valid
`ifdef MUX_SCANNER_CHANGE_EN
        , input changed
`endif
    );
endinterface

// File: rtl/mux_scan_settle_timer.sv
// mux_scan_settle_timer: counts 0..SETTLE while enabled; expire marks the sampling cycle
module mux_scan_settle_timer #(
    parameter int SETTLE = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);
    localparam int CW = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);
    logic [CW-1:0] cnt;
    assign expire = enable && (cnt == CW'(SETTLE));
    // wrap to zero on expiry so the next channel starts a fresh settle window
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (clear || expire)
            cnt <= '0;
        else if (enable)
            cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/mux_scanner.sv
// mux_scanner: steps an 8:1 mux through all channels, samples y after a settle
// window, and delivers the packed byte over valid/ready.
// Optional MUX_SCANNER_CHANGE_EN adds a changed flag against the last delivered byte.
module mux_scanner import mux_scanner_pkg::*; #(
    parameter int SETTLE = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    mux_scanner_if.master bus
);
    scan_state_t       state;
    logic [SEL_W-1:0]  ch;
    logic [NUM_CH-1:0] shadow;
    logic [NUM_CH-1:0] sh_next;
    logic [NUM_CH-1:0] data;
    logic              busy;
    logic              valid;
    logic              expire;
`ifdef MUX_SCANNER_CHANGE_EN
    logic [NUM_CH-1:0] prev;
    logic              changed;
    assign bus.changed = changed;
`endif

    assign {bus.sl_2, bus.sl_1, bus.sl_0} = ch;
    assign bus.busy  = busy;
    assign bus.data  = data;
    assign bus.valid = valid;

    mux_scan_settle_timer #(.SETTLE(SETTLE)) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (state != mux_scanner_pkg::SETTLE),
        .enable (state == mux_scanner_pkg::SETTLE),
        .expire (expire)
    );

    // shadow with the current channel's sample merged in; becomes data on the last channel
    always_comb begin
        sh_next     = shadow;
        sh_next[ch] = bus.y;
    end

    // scan FSM: IDLE waits for start, SETTLE walks the channels, DONE holds the result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            ch      <= '0;
            shadow  <= '0;
            data    <= '0;
            busy    <= 1'b0;
            valid   <= 1'b0;
`ifdef MUX_SCANNER_CHANGE_EN
            prev    <= '0;
            changed <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    shadow <= '0;
                    ch     <= '0;
                    busy   <= 1'b1;
                    state  <= mux_scanner_pkg::SETTLE;
                end
                mux_scanner_pkg::SETTLE: if (expire) begin
                    shadow <= sh_next;
                    if (ch == SEL_W'(NUM_CH - 1)) begin
                        data    <= sh_next;
                        valid   <= 1'b1;
                        ch      <= '0;
                        state   <= DONE;
`ifdef MUX_SCANNER_CHANGE_EN
                        changed <= (sh_next != prev);
`endif
                    end else begin
                        ch <= ch + 1'b1;
                    end
                end
                DONE: if (bus.ready) begin
                    valid   <= 1'b0;
                    busy    <= 1'b0;
                    state   <= IDLE;
`ifdef MUX_SCANNER_CHANGE_EN
                    prev    <= data;
                    changed <= 1'b0;
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mux_scanner.sv
// tb_mux_scanner: scoreboard bench for mux_scanner with SETTLE=1 and SETTLE=0 instances
module tb_mux_scanner;
    typedef struct {
        logic [7:0] d;
        int         c;
        logic       chg;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] in1 = 8'h00;
    logic [7:0] in0 = 8'h00;
    int         cyc = 0;
    int         nvec = 0;
    int         nerr = 0;
    exp_t       q1[$];
    exp_t       q0[$];

    mux_scanner_if bus1();
    mux_scanner_if bus0();

    assign bus1.y = in1[{bus1.sl_2, bus1.sl_1, bus1.sl_0}];
    assign bus0.y = in0[{bus0.sl_2, bus0.sl_1, bus0.sl_0}];

    mux_scanner #(.SETTLE(1)) u_s1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    mux_scanner #(.SETTLE(0)) u_s0 (.clk(clk), .rst_n(rst_n), .bus(bus0));

    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h required %0h", nm, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic wait_empty(input int budget);
        int n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (q0.size() != 0 || q1.size() != 0) begin
            nvec++;
            nerr++;
            $display("FAIL timeout: %0d results pending, required 0", q0.size() + q1.size());
            q0.delete();
            q1.delete();
        end
    endtask

    task automatic scan1(input logic [7:0] pat, input logic chg);
        in1 = pat;
        bus1.start = 1'b1;
        q1.push_back('{pat, cyc + 1 + 16, chg});
        @(negedge clk);
        bus1.start = 1'b0;
        wait_empty(60);
    endtask

    task automatic chk_idle(input string nm);
        chk({nm, "_s1"}, {bus1.sl_2, bus1.sl_1, bus1.sl_0, bus1.busy, bus1.valid}, 0);
        chk({nm, "_s0"}, {bus0.sl_2, bus0.sl_1, bus0.sl_0, bus0.busy, bus0.valid}, 0);
    endtask

    // monitor for the SETTLE=1 instance
    initial begin
        logic lv;
        exp_t e;
        lv = 1'b0;
        forever begin
            @(negedge clk);
            if (bus1.valid && !lv) begin
                if (q1.size() == 0) begin
                    nvec++;
                    nerr++;
                    $display("FAIL s1_unexpected_result: got %0h required none", bus1.data);
                end else begin
                    e = q1.pop_front();
                    chk("s1_data", bus1.data, e.d);
                    chk("s1_valid_cycle", cyc, e.c);
`ifdef MUX_SCANNER_CHANGE_EN
                    chk("s1_changed", bus1.changed, e.chg);
`endif
                end
            end
            lv = bus1.valid;
        end
    end

    // monitor for the SETTLE=0 instance
    initial begin
        logic lv;
        exp_t e;
        lv = 1'b0;
        forever begin
            @(negedge clk);
            if (bus0.valid && !lv) begin
                if (q0.size() == 0) begin
                    nvec++;
                    nerr++;
                    $display("FAIL s0_unexpected_result: got %0h required none", bus0.data);
                end else begin
                    e = q0.pop_front();
                    chk("s0_data", bus0.data, e.d);
                    chk("s0_valid_cycle", cyc, e.c);
`ifdef MUX_SCANNER_CHANGE_EN
                    chk("s0_changed", bus0.changed, e.chg);
`endif
                end
            end
            lv = bus0.valid;
        end
    end

    initial begin
        int acc;
        bus1.start = 1'b0;
        bus1.ready = 1'b0;
        bus0.start = 1'b0;
        bus0.ready = 1'b0;
        repeat (2) @(negedge clk);
        chk_idle("reset");
        chk("reset_data1", bus1.data, 8'h00);
        chk("reset_data0", bus0.data, 8'h00);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk_idle("idle5");

        // SETTLE=1, a..h = 1,0,1,1,0,0,1,0 -> 8'h4D, ready already high
        in1 = 8'h4D;
        bus1.ready = 1'b1;
        bus1.start = 1'b1;
        acc = cyc + 1;
        q1.push_back('{8'h4D, acc + 16, 1'b1});
        @(negedge clk);
        bus1.start = 1'b0;
        chk("s1_busy_after_start", {bus1.busy, bus1.sl_2, bus1.sl_1, bus1.sl_0}, 4'b1000);
        wait_cyc(acc + 6);
        chk("s1_select_ch3", {bus1.sl_2, bus1.sl_1, bus1.sl_0}, 3'd3);
        wait_cyc(acc + 16);
        chk("s1_valid_rise", bus1.valid, 1'b1);
        @(negedge clk);
        chk("s1_valid_one_cycle", {bus1.valid, bus1.busy}, 2'b00);

        // SETTLE=0, all ones, consumer stalls; start during DONE is ignored
        in0 = 8'hFF;
        bus0.start = 1'b1;
        acc = cyc + 1;
        q0.push_back('{8'hFF, acc + 8, 1'b1});
        @(negedge clk);
        bus0.start = 1'b0;
        wait_cyc(acc + 8);
        chk("s0_valid_rise", bus0.valid, 1'b1);
        for (int i = 0; i < 10; i++) begin
            bus0.start = i[0];
            @(negedge clk);
            chk("s0_hold", {bus0.valid, bus0.busy, bus0.data}, {2'b11, 8'hFF});
        end
        bus0.start = 1'b1;
        bus0.ready = 1'b1;
        @(negedge clk);
        chk("s0_transfer_ignores_start", {bus0.valid, bus0.busy, bus0.data}, {2'b00, 8'hFF});
        bus0.start = 1'b0;
        bus0.ready = 1'b0;
        @(negedge clk);
        chk("s0_stays_idle", bus0.busy, 1'b0);

        // abort at channel 4, then a fresh full scan
        in1 = 8'h5A;
        bus1.start = 1'b1;
        acc = cyc + 1;
        @(negedge clk);
        bus1.start = 1'b0;
        wait_cyc(acc + 8);
        chk("s1_select_ch4", {bus1.sl_2, bus1.sl_1, bus1.sl_0}, 3'd4);
        #1 rst_n = 1'b0;
        #1;
        chk_idle("abort");
        chk("abort_data1", bus1.data, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        scan1(8'hA5, 1'b1);

        // back-to-back with start held high on SETTLE=0
        in0 = 8'h3C;
        bus0.ready = 1'b1;
        bus0.start = 1'b1;
        acc = cyc + 1;
        q0.push_back('{8'h3C, acc + 8, 1'b1});
        q0.push_back('{8'h3C, acc + 18, 1'b0});
        q0.push_back('{8'h3C, acc + 28, 1'b0});
        wait_cyc(acc + 28);
        bus0.start = 1'b0;
        wait_empty(60);
        repeat (3) @(negedge clk);
        chk("s0_b2b_idle", {bus0.busy, bus0.valid}, 2'b00);

`ifdef MUX_SCANNER_CHANGE_EN
        scan1(8'h4D, 1'b1);
        scan1(8'h4D, 1'b0);
        scan1(8'h49, 1'b1);
`endif
        wait_empty(60);
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
